trig_delay_meter: RTL and testbench
===================================

Name: trig_delay_meter

Overview:
- Synchronous measurement front-end for adder-delay characterisation benches.
- Registers a WIDTH-bit stimulus word onto a level bus (bit-to-level conversion).
- Generates a divided free-running stimulus clock.
- Measures, in clk cycles, the delay from a rising edge on a "from" trigger to the next rising edge on a "to" trigger.

Parameters:
- WIDTH, 8: stimulus/level bus width (>=1).
- DIV, 2: gen_clk period in clk cycles; even, >=2.
- CNT_W, 16: delay counter width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bits  input  WIDTH  stimulus bits.
- lvl_out  output  WIDTH  registered level image of in_bits.
- gen_clk  output  1  divided clock, 50% duty.
- gen_tick  output  1  one-cycle pulse coincident with each gen_clk 0->1.
- from_trig  input  1  measurement start trigger.
- to_trig  input  1  measurement stop trigger.
- delay_cnt  output  CNT_W  last measured delay in clk cycles.
- delay_valid  output  1  one-cycle pulse when delay_cnt updates.
- busy  output  1  high while a measurement is open.
- overflow  output  1  sticky; set when the counter saturates.

Behaviour:
- Reset (async assert, sync release) clears every output and internal register to 0. State goes to IDLE.
- Level path: lvl_out <= in_bits every cycle. Latency is 1 clk. No other transformation.
- Clock generator:
  - A divide counter runs 0..DIV/2-1; gen_clk toggles when it wraps.
  - The first gen_clk rise comes DIV/2 clk edges after reset release; the period is DIV thereafter.
  - gen_tick = 1 in the cycle gen_clk is registered 0->1.
- Trigger edge detection:
  - from_q and to_q hold the previous samples (reset 0).
  - rise_from = from_trig & ~from_q; rise_to = to_trig & ~to_q.
  - A level already high at reset release counts as a rise on the first edge.
- State machine, IDLE / COUNT:
  - IDLE, rise_from and no rise_to: cnt <= 0, go to COUNT, busy = 1.
  - IDLE, rise_to alone: ignored.
  - IDLE, rise_from and rise_to on the same edge: delay_cnt <= 0, delay_valid pulses, stay IDLE.
  - COUNT, no rise_to: cnt <= cnt+1, saturating at 2^CNT_W-1. Reaching saturation sets overflow.
  - COUNT, rise_to: delay_cnt <= cnt+1 (saturated), delay_valid pulses for one cycle, go to IDLE.
  - COUNT, rise_from without rise_to: restart. cnt <= 0, stay in COUNT; the most recent start wins.
  - COUNT, rise_from and rise_to together: close the current measurement first. Report cnt+1, then go to IDLE.
- Resulting delay: rise_from sampled at edge k and rise_to at edge k+n gives delay_cnt = n, visible after edge k+n.
- delay_cnt holds its value between measurements.
- overflow clears only on reset.
- Reset mid-measurement: returns to IDLE and clears delay_cnt, busy and overflow.

Optional Feature:
- Macro: TRIG_DELAY_MINMAX_EN.
- Defined:
  - Adds outputs delay_min and delay_max, each CNT_W bits.
  - On each delay_valid, delay_min <= min(delay_min, new delay) and delay_max <= max(delay_max, new delay).
  - Reset values: delay_min = all ones, delay_max = 0.
  - Both update in the same cycle as delay_cnt.
- Undefined: the ports and their registers are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 mid-operation, then release -> all outputs 0. With DIV=2, the first gen_clk rise and gen_tick come 1 edge after release and toggle every edge. With DIV=8, period is 8 cycles with 4 high / 4 low.
- Level path: in_bits 8'hFF, 8'h00, 8'hA5 on consecutive cycles -> lvl_out shows the same sequence one cycle later.
- Basic delay: from_trig rises at edge 10, to_trig rises at edge 15 -> delay_cnt=5, delay_valid high for exactly one cycle, busy high over edges 10..14.
- Restart and ignore:
  - to_trig rise while IDLE -> no valid pulse.
  - from at edge 0, from again at edge 4, to at edge 7 -> delay_cnt=3.
- Simultaneous/saturation:
  - from and to rising on the same edge in IDLE -> delay_cnt=0 with a valid pulse.
  - CNT_W=4 with 20 cycles between triggers -> delay_cnt=15, overflow=1 sticky until reset.
- With TRIG_DELAY_MINMAX_EN: delays 5, 2, 9 -> delay_min=2, delay_max=9.

Source files
------------

// File: rtl/trig_delay_meter.sv
// Adder-delay bench front-end: level bus register, divided stimulus clock and
// from->to trigger delay meter. Define TRIG_DELAY_MINMAX_EN to add delay_min/delay_max tracking.
module trig_delay_meter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_bits,
  output logic [WIDTH-1:0] lvl_out,
  output logic             gen_clk,
  output logic             gen_tick,
  input  logic             from_trig,
  input  logic             to_trig,
  output logic [CNT_W-1:0] delay_cnt,
  output logic             delay_valid,
  output logic             busy,
  output logic             overflow
`ifdef TRIG_DELAY_MINMAX_EN
  ,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max
`endif
);

  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lvl_q, lvl_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             gclk_q, gclk_d, tick_q, tick_d;
  logic             from_q, to_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, delay_q, delay_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic             div_wrap, rise_from, rise_to;

  always_comb begin
    lvl_d    = in_bits;
    div_wrap = (div_q == DIV_LAST);
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    gclk_d   = div_wrap ? ~gclk_q : gclk_q;
    tick_d   = div_wrap & ~gclk_q;
  end

  always_comb begin
    rise_from = from_trig & ~from_q;
    rise_to   = to_trig & ~to_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
    state_d   = state_q;
    cnt_d     = cnt_q;
    delay_d   = delay_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (rise_from && rise_to) begin
          delay_d = '0;
          valid_d = 1'b1;
        end else if (rise_from) begin
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // A stop edge always closes the open measurement, even if a start coincides.
        if (rise_to) begin
          delay_d = cnt_inc;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (rise_from) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lvl_q   <= '0;
      div_q   <= '0;
      gclk_q  <= 1'b0;
      tick_q  <= 1'b0;
      from_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      delay_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      div_q   <= div_d;
      gclk_q  <= gclk_d;
      tick_q  <= tick_d;
      from_q  <= from_trig;
      to_q    <= to_trig;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign lvl_out     = lvl_q;
  assign gen_clk     = gclk_q;
  assign gen_tick    = tick_q;
  assign delay_cnt   = delay_q;
  assign delay_valid = valid_q;
  assign busy        = (state_q == COUNT);
  assign overflow    = ovf_q;

`ifdef TRIG_DELAY_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (valid_d) begin
      if (delay_d < min_q) min_d = delay_d;
      if (delay_d > max_q) max_d = delay_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign delay_min = min_q;
  assign delay_max = max_q;
`endif

endmodule

// File: tb/tb_trig_delay_meter.sv
// Directed bench for trig_delay_meter: a default instance plus a DIV=8/CNT_W=4 instance
// sharing clock, reset and stimulus.
module tb_trig_delay_meter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_bits = '0;
  logic       from_trig = 1'b0;
  logic       to_trig = 1'b0;

  logic [7:0]  lvl_out, s_lvl_out;
  logic        gen_clk, gen_tick, s_gen_clk, s_gen_tick;
  logic [15:0] delay_cnt;
  logic [3:0]  s_delay_cnt;
  logic        delay_valid, busy, overflow;
  logic        s_delay_valid, s_busy, s_overflow;
`ifdef TRIG_DELAY_MINMAX_EN
  logic [15:0] delay_min, delay_max;
  logic [3:0]  s_delay_min, s_delay_max;
`endif

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trig_delay_meter #(.WIDTH(8), .DIV(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_bits(in_bits), .lvl_out(lvl_out),
    .gen_clk(gen_clk), .gen_tick(gen_tick), .from_trig(from_trig), .to_trig(to_trig),
    .delay_cnt(delay_cnt), .delay_valid(delay_valid), .busy(busy), .overflow(overflow)
`ifdef TRIG_DELAY_MINMAX_EN
    , .delay_min(delay_min), .delay_max(delay_max)
`endif
  );

  trig_delay_meter #(.WIDTH(8), .DIV(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_bits(in_bits), .lvl_out(s_lvl_out),
    .gen_clk(s_gen_clk), .gen_tick(s_gen_tick), .from_trig(from_trig), .to_trig(to_trig),
    .delay_cnt(s_delay_cnt), .delay_valid(s_delay_valid), .busy(s_busy), .overflow(s_overflow)
`ifdef TRIG_DELAY_MINMAX_EN
    , .delay_min(s_delay_min), .delay_max(s_delay_max)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic exp_g, exp_t, exp_sg, exp_st;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({lvl_out, gen_clk, gen_tick, delay_cnt, delay_valid, busy, overflow} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_main: got %h expected 0",
               {lvl_out, gen_clk, gen_tick, delay_cnt, delay_valid, busy, overflow});
    end
    n_checks++;
    if ({s_lvl_out, s_gen_clk, s_gen_tick, s_delay_cnt, s_delay_valid, s_busy, s_overflow} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_small: got %h expected 0",
               {s_lvl_out, s_gen_clk, s_gen_tick, s_delay_cnt, s_delay_valid, s_busy, s_overflow});
    end
`ifdef TRIG_DELAY_MINMAX_EN
    n_checks++;
    if (delay_min !== 16'hFFFF || delay_max !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_minmax: got min %h max %h expected ffff 0000", delay_min, delay_max);
    end
`endif
    from_trig = 1'b0;
    to_trig   = 1'b0;
    in_bits   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step();
      exp_g  = (e % 2) == 1;
      exp_t  = exp_g;
      exp_sg = ((e / 4) % 2) == 1;
      exp_st = exp_sg && ((e % 4) == 0);
      n_checks++;
      if (gen_clk !== exp_g || gen_tick !== exp_t) begin
        n_fail++;
        $display("FAIL gen_div2 edge %0d: got clk %b tick %b expected %b %b", e, gen_clk, gen_tick, exp_g, exp_t);
      end
      n_checks++;
      if (s_gen_clk !== exp_sg || s_gen_tick !== exp_st) begin
        n_fail++;
        $display("FAIL gen_div8 edge %0d: got clk %b tick %b expected %b %b", e, s_gen_clk, s_gen_tick, exp_sg, exp_st);
      end
    end
  endtask

  task automatic test_level;
    logic [7:0] vec [3];
    vec[0] = 8'hFF; vec[1] = 8'h00; vec[2] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      in_bits = vec[i];
      step();
      n_checks++;
      if (lvl_out !== vec[i] || s_lvl_out !== vec[i]) begin
        n_fail++;
        $display("FAIL level %0d: got %h/%h expected %h", i, lvl_out, s_lvl_out, vec[i]);
      end
    end
    in_bits = '0;
  endtask

  task automatic test_basic;
    from_trig = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_start: got %b expected 1", busy);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_checks++;
      if (busy !== 1'b1 || delay_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_open %0d: got busy %b valid %b expected 1 0", i, busy, delay_valid);
      end
    end
    to_trig = 1'b1;
    step();
    n_checks++;
    if (delay_cnt !== 16'd5 || delay_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_close: got cnt %0d valid %b busy %b expected 5 1 0", delay_cnt, delay_valid, busy);
    end
    n_checks++;
    if (s_delay_cnt !== 4'd5 || s_delay_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_close_small: got cnt %0d valid %b expected 5 1", s_delay_cnt, s_delay_valid);
    end
    from_trig = 1'b0;
    to_trig   = 1'b0;
    step();
    n_checks++;
    if (delay_valid !== 1'b0 || delay_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL basic_hold: got valid %b cnt %0d expected 0 5", delay_valid, delay_cnt);
    end
  endtask

  task automatic test_ignore;
    to_trig = 1'b1;
    step();
    n_checks++;
    if (delay_valid !== 1'b0 || busy !== 1'b0 || delay_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL ignore_to: got valid %b busy %b cnt %0d expected 0 0 5", delay_valid, busy, delay_cnt);
    end
    to_trig = 1'b0;
    step();
  endtask

  task automatic test_restart;
    from_trig = 1'b1;
    step();
    from_trig = 1'b0;
    repeat (3) step();
    from_trig = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b1 || delay_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_open: got busy %b valid %b expected 1 0", busy, delay_valid);
    end
    from_trig = 1'b0;
    repeat (2) step();
    to_trig = 1'b1;
    step();
    n_checks++;
    if (delay_cnt !== 16'd3 || delay_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_close: got cnt %0d valid %b expected 3 1", delay_cnt, delay_valid);
    end
    to_trig = 1'b0;
    step();
  endtask

  task automatic test_simultaneous;
    from_trig = 1'b1;
    to_trig   = 1'b1;
    step();
    n_checks++;
    if (delay_cnt !== 16'd0 || delay_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_idle: got cnt %0d valid %b busy %b expected 0 1 0", delay_cnt, delay_valid, busy);
    end
    from_trig = 1'b0;
    to_trig   = 1'b0;
    step();
    n_checks++;
    if (delay_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_pulse: got valid %b expected 0", delay_valid);
    end
    from_trig = 1'b1;
    step();
    from_trig = 1'b0;
    repeat (2) step();
    from_trig = 1'b1;
    to_trig   = 1'b1;
    step();
    n_checks++;
    if (delay_cnt !== 16'd3 || delay_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_count: got cnt %0d valid %b busy %b expected 3 1 0", delay_cnt, delay_valid, busy);
    end
    from_trig = 1'b0;
    to_trig   = 1'b0;
    step();
  endtask

  task automatic test_saturation;
    from_trig = 1'b1;
    step();
    from_trig = 1'b0;
    repeat (19) step();
    to_trig = 1'b1;
    step();
    n_checks++;
    if (s_delay_cnt !== 4'd15 || s_overflow !== 1'b1 || s_delay_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_small: got cnt %0d ovf %b valid %b expected 15 1 1", s_delay_cnt, s_overflow, s_delay_valid);
    end
    n_checks++;
    if (delay_cnt !== 16'd20 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_main: got cnt %0d ovf %b expected 20 0", delay_cnt, overflow);
    end
    to_trig = 1'b0;
    repeat (3) step();
    from_trig = 1'b1;
    step();
    from_trig = 1'b0;
    to_trig = 1'b1;
    step();
    n_checks++;
    if (s_overflow !== 1'b1 || s_delay_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL sat_sticky: got ovf %b cnt %0d expected 1 1", s_overflow, s_delay_cnt);
    end
    to_trig = 1'b0;
    step();
  endtask

`ifdef TRIG_DELAY_MINMAX_EN
  task automatic measure(input int n);
    from_trig = 1'b1;
    step();
    from_trig = 1'b0;
    repeat (n - 1) step();
    to_trig = 1'b1;
    step();
    to_trig = 1'b0;
    step();
  endtask

  task automatic test_minmax;
    measure(5);
    n_checks++;
    if (delay_min !== 16'd5 || delay_max !== 16'd5) begin
      n_fail++;
      $display("FAIL minmax_first: got min %0d max %0d expected 5 5", delay_min, delay_max);
    end
    measure(2);
    measure(9);
    n_checks++;
    if (delay_min !== 16'd2 || delay_max !== 16'd9) begin
      n_fail++;
      $display("FAIL minmax_final: got min %0d max %0d expected 2 9", delay_min, delay_max);
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    from_trig = 1'b1;
    in_bits = 8'h3C;
    step();
    step();
    test_reset();
    test_level();
    test_basic();
    test_ignore();
    test_restart();
    test_simultaneous();
    test_saturation();
    test_reset();
`ifdef TRIG_DELAY_MINMAX_EN
    test_minmax();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
